// File: rtl/y_reg_file_pkg.sv
// Shared register-file constants and types, also used by the ALU, decode and
// write-back stages.
package y_reg_file_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_NREG  = 32;
  localparam int RF_AW    = 5;
  localparam int ZERO_REG = 0;

  typedef logic [RF_NREG-1:0]  rf_wen_t;
  typedef logic [RF_WIDTH-1:0] rf_word_t;

endpackage

// File: rtl/y_rf_decode.sv
// Write-address decoder: wr_en + wr_addr -> one-hot register enable vector,
// with the zero register never enabled. Gate-level, like the datapath.
module y_rf_decode
  import y_reg_file_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int AW   = RF_AW
) (
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  output logic [NREG-1:0] wen_o
);

  logic [AW-1:0] addr_n;

  for (genvar j = 0; j < AW; j++) begin : g_inv
    not u_inv (addr_n[j], wr_addr_i[j]);
  end

  assign wen_o[ZERO_REG] = 1'b0;

  for (genvar i = 0; i < NREG; i++) begin : g_row
    if (i != ZERO_REG) begin : g_dec
      // Each row is an AND chain of wr_en and the matching address literals.
      for (genvar j = 0; j < AW; j++) begin : g_bit
        logic lit;
        logic t;
        if (((i >> j) & 1) != 0) begin : g_pos
          buf u_lit (lit, wr_addr_i[j]);
        end else begin : g_neg
          buf u_lit (lit, addr_n[j]);
        end
        if (j == 0) begin : g_first
          and u_and (t, wr_en_i, lit);
        end else begin : g_next
          and u_and (t, g_bit[j-1].t, lit);
        end
      end
      buf u_out (wen_o[i], g_bit[AW-1].t);
    end
  end

endmodule

// File: rtl/y_reg_file.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, r0 hardwired to zero, optional write-through bypass.
module y_reg_file
  import y_reg_file_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int NREG   = RF_NREG,
  parameter int AW     = RF_AW,
  parameter int BYPASS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rs_addr,
  input  logic [AW-1:0]    rt_addr,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic            wr_go;
  logic [NREG-1:0] wen;
  logic            unused_wen0;

  // Reset dominates: a write on a reset edge never reaches the decoder.
  assign wr_go       = wr_en & ~reset;
  assign unused_wen0 = wen[ZERO_REG];

  y_rf_decode #(
    .NREG (NREG),
    .AW   (AW)
  ) u_dec (
    .wr_en_i   (wr_go),
    .wr_addr_i (wr_addr),
    .wen_o     (wen)
  );

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (i != ZERO_REG) begin : g_st
      logic [WIDTH-1:0] q_q;
      logic [WIDTH-1:0] q_d;

      always_comb q_d = wen[i] ? wr_data : q_q;

      always_ff @(posedge clk) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
      end
    end
  end

  // Read trees: level AW holds the registers, each level above is a row of
  // 2:1 muxes steered by one address bit, MSB at the root.
  for (genvar lv = 0; lv <= AW; lv++) begin : g_lvl
    logic [WIDTH-1:0] rs_n [2**lv];
    logic [WIDTH-1:0] rt_n [2**lv];
    for (genvar k = 0; k < 2**lv; k++) begin : g_node
      if (lv == AW) begin : g_leaf
        if (k == ZERO_REG) begin : g_zero
          assign rs_n[k] = '0;
          assign rt_n[k] = '0;
        end else begin : g_val
          assign rs_n[k] = g_reg[k].g_st.q_q;
          assign rt_n[k] = g_reg[k].g_st.q_q;
        end
      end else begin : g_mux
        assign rs_n[k] = rs_addr[AW-1-lv] ? g_lvl[lv+1].rs_n[2*k+1]
                                          : g_lvl[lv+1].rs_n[2*k];
        assign rt_n[k] = rt_addr[AW-1-lv] ? g_lvl[lv+1].rt_n[2*k+1]
                                          : g_lvl[lv+1].rt_n[2*k];
      end
    end
  end

  logic [WIDTH-1:0] rs_tree;
  logic [WIDTH-1:0] rt_tree;

  assign rs_tree = g_lvl[0].rs_n[0];
  assign rt_tree = g_lvl[0].rt_n[0];

  if (BYPASS != 0) begin : g_byp
    // wen already excludes reset and r0, so it is exactly the bypass hit.
    assign rs_data = wen[rs_addr] ? wr_data : rs_tree;
    assign rt_data = wen[rt_addr] ? wr_data : rt_tree;
  end else begin : g_nobyp
    assign rs_data = rs_tree;
    assign rt_data = rt_tree;
  end

endmodule

// File: tb/tb_y_reg_file.sv
// Bench for y_reg_file: unbypassed and bypassed instances share stimulus and
// are checked against a 32-entry reference array through a scoreboard queue.
module tb_y_reg_file;
  import y_reg_file_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rs0, rt0, rs1, rt1;

  always #5 clk = ~clk;

  y_reg_file #(.BYPASS(0)) u_dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs0), .rt_data(rt0), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  y_reg_file #(.BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs1), .rt_data(rt1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  typedef struct {
    string       tag;
    logic [31:0] rs, rt, brs, brt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mdl[a];
  endfunction

  function automatic logic [31:0] rdb(input logic [4:0] a);
    if (wr_en && !reset && wr_addr != 5'd0 && wr_addr == a) return wr_data;
    return rd(a);
  endfunction

  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra,
                      input logic [4:0] rb, input string tag);
    exp_t e;
    reset   = rst;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rs_addr = ra;
    rt_addr = rb;
    e.tag = tag;
    e.rs  = rd(ra);
    e.rt  = rd(rb);
    e.brs = rdb(ra);
    e.brt = rdb(rb);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".rs"},  rs0, e.rs);
    chk({e.tag, ".rt"},  rt0, e.rt);
    chk({e.tag, ".brs"}, rs1, e.brs);
    chk({e.tag, ".brt"}, rt1, e.brt);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else if (we && wa != 5'd0) begin
      mdl[wa] = wd;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = '0; rt_addr = '0;
    @(negedge clk);

    // r0 reads zero even before the first reset edge.
    step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "rst_r0");
    for (int a = 0; a < 32; a++)
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), "sweep");

    step(1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 5'd0, 5'd0, "wr5");
    step(1'b0, 1'b1, 5'd31, 32'h0000_0001, 5'd5, 5'd0, "wr31");
    for (int n = 0; n < 3; n++)
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, "rd5_31");

    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "wr0");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "rd0");
    for (int a = 1; a < 32; a++)
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(a), "keep");

    step(1'b0, 1'b1, 5'd7, 32'h11, 5'd7, 5'd5, "wr7a");
    step(1'b0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7, "wt7");
    step(1'b0, 1'b0, 5'd0, 32'h0,  5'd7, 5'd7, "rd7");

    step(1'b1, 1'b1, 5'd3, 32'hABCD, 5'd3, 5'd5, "rstwr");
    step(1'b0, 1'b0, 5'd0, 32'h0,    5'd3, 5'd5, "post_rst");

    for (int n = 0; n < 10000; n++)
      step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), $urandom(),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
